// File: rtl/uart_rx_ref.sv
// uart_rx_ref: 8N1 UART receiver, companion to uart_tx_ref, in the sys_clk domain.
// The serial line is synchronised, then a falling edge starts a frame. The start bit is
// re-checked at half a bit. Data, optional parity and stop bits are each sampled at a bit
// centre.
// Optional build macro UART_RX_PARITY_EN adds an even-parity bit and a uart_rx_parity_err strobe.
module uart_rx_ref #(
  parameter int unsigned BPS     = 9600,
  parameter int unsigned CLK_FRE = 50_000_000
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       uart_rxd,
  output logic [7:0] uart_rx_data,
  output logic       uart_rx_done,
  output logic       uart_rx_frame_err,
  output logic       uart_rx_busy
`ifdef UART_RX_PARITY_EN
  ,
  output logic       uart_rx_parity_err
`endif
);

  localparam int unsigned BAUD_CNT_MAX  = CLK_FRE / BPS;
  localparam int unsigned BAUD_CNT_HALF = BAUD_CNT_MAX / 2;
  localparam int unsigned CW            = $clog2(BAUD_CNT_MAX);

  localparam logic [CW-1:0] CntLast     = CW'(BAUD_CNT_MAX - 1);
  localparam logic [CW-1:0] CntHalfLast = CW'(BAUD_CNT_HALF - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    data_q, data_d;
  logic          done_q, done_d;
  logic          ferr_q, ferr_d;
`ifdef UART_RX_PARITY_EN
  logic          par_q, par_d;
  logic          perr_q, perr_d;
`endif

  logic rx_sync1_q, rx_sync2_q, rx_prev_q;
  logic rx_fall;

  // Two-flop synchroniser plus a history flop for falling-edge detection.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      rx_sync1_q <= 1'b1;
      rx_sync2_q <= 1'b1;
      rx_prev_q  <= 1'b1;
    end else begin
      rx_sync1_q <= uart_rxd;
      rx_sync2_q <= rx_sync1_q;
      rx_prev_q  <= rx_sync2_q;
    end
  end

  // Only a fresh 1->0 transition counts; a line held low never retriggers.
  assign rx_fall = rx_prev_q & ~rx_sync2_q;

  // State, counters, shift register and registered strobes.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      done_q    <= 1'b0;
      ferr_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q     <= 1'b0;
      perr_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      done_q    <= done_d;
      ferr_q    <= ferr_d;
`ifdef UART_RX_PARITY_EN
      par_q     <= par_d;
      perr_q    <= perr_d;
`endif
    end
  end

  // Next-state logic: bit-centre sampling and frame checking.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    data_d    = data_q;
    done_d    = 1'b0;
    ferr_d    = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d     = par_q;
    perr_d    = 1'b0;
`endif
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (rx_fall) begin
          state_d = StStart;
        end
      end
      StStart: begin
        if (cnt_q == CntHalfLast) begin
          cnt_d     = '0;
          bit_cnt_d = '0;
          // A start bit that is high again at half a bit was a glitch.
          state_d   = rx_sync2_q ? StIdle : StData;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      StData: begin
        if (cnt_q == CntLast) begin
          cnt_d              = '0;
          shift_d[bit_cnt_q] = rx_sync2_q;
          bit_cnt_d          = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = StParity;
`else
            state_d = StStop;
`endif
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      StParity: begin
`ifdef UART_RX_PARITY_EN
        if (cnt_q == CntLast) begin
          cnt_d   = '0;
          par_d   = rx_sync2_q;
          state_d = StStop;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
`else
        state_d = StIdle;
`endif
      end
      StStop: begin
        if (cnt_q == CntLast) begin
          cnt_d   = '0;
          // Back to idle mid-stop-bit so a following start edge is not missed.
          state_d = StIdle;
          if (!rx_sync2_q) begin
            ferr_d = 1'b1;
`ifdef UART_RX_PARITY_EN
          end else if (par_q != ^shift_q) begin
            perr_d = 1'b1;
`endif
          end else begin
            data_d = shift_q;
            done_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign uart_rx_data      = data_q;
  assign uart_rx_done      = done_q;
  assign uart_rx_frame_err = ferr_q;
  assign uart_rx_busy      = (state_q != StIdle);
`ifdef UART_RX_PARITY_EN
  assign uart_rx_parity_err = perr_q;
`endif

endmodule

// File: doc/uart_rx_ref.md
Name: uart_rx_ref

Overview:
UART receiver that complements the team's uart_tx_ref transmitter. It deserialises 8N1 frames (1 start, 8 data LSB-first, 1 stop) from an asynchronous serial line into bytes. A one-cycle done strobe marks each good byte, and a one-cycle error strobe marks each bad frame. It sits between the board RX pin and the user logic, in the same sys_clk domain as uart_tx_ref.

Parameters:
BPS, 9600, baud rate in bit/s.
CLK_FRE, 50_000_000, sys_clk frequency in Hz.
(derived localparam) BAUD_CNT_MAX = CLK_FRE / BPS (integer division), 5208 at defaults.
(derived localparam) BAUD_CNT_HALF = BAUD_CNT_MAX / 2, 2604 at defaults.

Ports:
sys_clk  input  1  system clock; all logic on its rising edge.
sys_rst  input  1  reset; synchronous, active-high.
uart_rxd  input  1  asynchronous serial line; idles high.
uart_rx_data  output  8  last correctly received byte; held until the next good frame.
uart_rx_done  output  1  one-cycle strobe; uart_rx_data is valid and updated in this cycle.
uart_rx_frame_err  output  1  one-cycle strobe; stop bit was sampled low.
uart_rx_busy  output  1  high whenever the state machine is not IDLE.

Behaviour:
- Reset (sys_rst=1 at a sys_clk edge):
  - State returns to IDLE; baud counter and bit counter clear to 0.
  - Both synchroniser flops are set to 1.
  - uart_rx_data=8'h00; uart_rx_done=0; uart_rx_frame_err=0; uart_rx_busy=0.
  - A reset mid-frame abandons the frame with no strobe.
- Input conditioning:
  - uart_rxd passes through a 2-flop synchroniser, then a third flop for edge detection.
  - A start condition is a falling edge of the synchronised signal (previous 1, current 0).
- IDLE: wait for a falling edge, then go to START with the baud counter at 0.
  - A line held low, e.g. after a break or framing error, must not retrigger. Only a fresh 1->0 edge starts a frame.
- START: the baud counter counts up.
  - At count BAUD_CNT_HALF-1, sample the line.
  - Sample 0: go to DATA with counter 0 and bit counter 0.
  - Sample 1 (glitch): return to IDLE silently.
- DATA: the counter runs 0..BAUD_CNT_MAX-1, then wraps.
  - At BAUD_CNT_MAX-1, sample into shift register bit [bit_cnt], LSB first, and increment bit_cnt.
  - After bit 7 is sampled, go to STOP (or to PARITY when the optional feature is enabled).
  - All samples land at bit centres, with +/-1 sys_clk quantisation.
- STOP: sample at count BAUD_CNT_MAX-1.
  - Sample 1: load uart_rx_data from the shift register and pulse uart_rx_done in the next cycle.
  - Sample 0: pulse uart_rx_frame_err in the next cycle; uart_rx_data is unchanged.
  - Either way, return to IDLE in the same cycle as the strobe.
- Strobe timing: each strobe lasts exactly 1 sys_clk. It occurs 9.5 bit times (+1 cycle of synchroniser latency + 1 cycle of register latency) after the start edge.
  - Because the strobe occurs mid-stop-bit, a back-to-back start edge arriving half a bit later is caught with no gap required.
- uart_rx_done and uart_rx_frame_err are never high together.
- uart_rx_busy is high from the cycle after the start edge is detected until the cycle of return to IDLE.
- Counter width is $clog2(BAUD_CNT_MAX); the bit counter is 3 bits; no overflow is possible.

Optional Feature:
Macro UART_RX_PARITY_EN.
- Defined:
  - A PARITY state is inserted between DATA and STOP; it samples one even-parity bit at a bit centre.
  - A port uart_rx_parity_err (output, 1) is added.
  - If the stop bit is good but parity mismatches, uart_rx_parity_err pulses for 1 cycle, uart_rx_done stays 0, and data is not updated.
  - If the stop bit is bad, only uart_rx_frame_err pulses, regardless of parity.
  - Frame length is 11 bits; the strobe occurs at 10.5 bit times.
- Undefined: no PARITY state, no uart_rx_parity_err port; behaviour is pure 8N1.

Test Plan:
1. Reset, then drive the 8N1 frame 0xA5 at 104166 ns/bit. Expect one uart_rx_done pulse at ~989.6 us after the start edge, uart_rx_data=8'hA5, and uart_rx_frame_err=0 throughout.
2. Drive a 1000 ns low glitch on uart_rxd. Expect uart_rx_busy high for ~BAUD_CNT_HALF cycles, then 0; no done or error strobe; uart_rx_data unchanged.
3. Receive 0xA5, then send frame 0x3C with the stop bit forced 0. Expect a single uart_rx_frame_err pulse, uart_rx_done=0, and uart_rx_data still 8'hA5. Keep the line low for a further 5 bit times and expect no new frame starts.
4. Send 0x00 then 0xFF back-to-back with zero idle gap. Expect two uart_rx_done pulses, 10 bit times apart, with data 8'h00 then 8'hFF.
5. Assert sys_rst for 1 cycle during bit 4 of frame 0x55, then send 0x81. Expect no strobe for the aborted frame, and exactly one uart_rx_done with data 8'h81.
6. With UART_RX_PARITY_EN defined:
   - Send 0x07 with parity bit 1: expect done with data 8'h07.
   - Resend 0x07 with parity bit 0: expect a uart_rx_parity_err pulse, no done, and data still 8'h07.
